// File: rtl/spi_bus_arbiter_pkg.sv
// Shared SPI definitions: requester indices, chip-select idle value,
// arbiter/shifter state encodings and the round-robin pick helper.
package spi_bus_arbiter_pkg;

  localparam int REQ_SD   = 0;
  localparam int REQ_SPI1 = 1;

  localparam logic [1:0] CS_IDLE = 2'b11;

  // Arbiter-level states; the bit-level LEAD/LOW/HIGH phases live in the shifter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE,
    ST_HOLD,
    ST_GAP
  } arb_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LEAD,
    PH_LOW,
    PH_HIGH
  } phase_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // A lone requester wins outright; on a tie the one not granted last wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    if (valid[REQ_SD] && valid[REQ_SPI1]) return ~last_grant;
    return valid[REQ_SPI1];
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_shift.sv
// Mode-0, MSB-first byte shifter: phase/bit counters, shift and receive
// registers, SCLK/MOSI generation. 'done' is high in the last cycle of a byte.
module spi_shift_byte
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned DIVIDE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       from_hold,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  localparam logic [7:0] DIV_LOAD = 8'(DIVIDE - 1);

  phase_t     phase;
  logic [7:0] phase_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  assign done    = (phase == PH_HIGH) && (phase_cnt == 8'd0) && (bit_cnt == 3'd0);
  assign rx_byte = rx_sr;

  // Phase sequencing: LEAD (fresh CS only), then LOW/HIGH per bit, MISO taken as SCLK rises.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= PH_IDLE;
      phase_cnt <= 8'd0;
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'd0;
      rx_sr     <= 8'd0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          if (start) begin
            tx_sr     <= tx_byte;
            bit_cnt   <= 3'd7;
            phase_cnt <= DIV_LOAD;
            mosi      <= tx_byte[7];
            sclk      <= 1'b0;
            phase     <= from_hold ? PH_LOW : PH_LEAD;
          end
        end
        PH_LEAD: begin
          if (phase_cnt == 8'd0) begin
            phase_cnt <= DIV_LOAD;
            phase     <= PH_LOW;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        PH_LOW: begin
          if (phase_cnt == 8'd0) begin
            phase_cnt <= DIV_LOAD;
            sclk      <= 1'b1;
            rx_sr     <= {rx_sr[6:0], miso};
            phase     <= PH_HIGH;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        PH_HIGH: begin
          if (phase_cnt == 8'd0) begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd0) begin
              phase <= PH_IDLE;
            end else begin
              bit_cnt   <= bit_cnt - 3'd1;
              tx_sr     <= {tx_sr[6:0], 1'b0};
              mosi      <= tx_sr[6];
              phase_cnt <= DIV_LOAD;
              phase     <= PH_LOW;
            end
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter: round-robin grant, per-requester chip
// select, CS hold (lock) for multi-byte transactions, post-release CS gap.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned DIVIDE = 4,
  parameter int unsigned GAP    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] tx_data_0,
  input  logic [7:0] tx_data_1,
  input  logic [1:0] hold_cs,
  input  logic [1:0] release_cs,
  output logic [1:0] rsp_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [1:0] spi_cs
);

  localparam logic [7:0] GAP_LOAD = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam arb_state_t AFTER_RELEASE = (GAP == 0) ? ST_IDLE : ST_GAP;

  arb_state_t state;
  logic       owner;
  logic       last_grant;
  logic       hold_flag;
  logic [7:0] gap_cnt;

  logic       winner;
  logic       acc_idx;
  logic       accept;
  logic       shift_done;
  logic [7:0] shift_rx;

  // Grant decode: round-robin winner in IDLE, owner only while holding CS.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    winner    = rr_pick(req_valid, last_grant);
    req_ready = 2'b00;
    if (state == ST_IDLE && |req_valid) req_ready = req_onehot(winner);
    else if (state == ST_HOLD)          req_ready = req_onehot(owner);
  end

  assign acc_idx = (state == ST_HOLD) ? owner : winner;
  assign accept  = |(req_valid & req_ready);
  assign busy    = (state != ST_IDLE);

  spi_shift_byte #(.DIVIDE(DIVIDE)) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (accept),
    .from_hold (state == ST_HOLD),
    .tx_byte   (acc_idx ? tx_data_1 : tx_data_0),
    .miso      (spi_miso),
    .done      (shift_done),
    .rx_byte   (shift_rx),
    .sclk      (spi_clk),
    .mosi      (spi_mosi)
  );

  // Arbiter FSM: ownership, chip selects, response pulse and gap timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      hold_flag  <= 1'b0;
      gap_cnt    <= 8'd0;
      spi_cs     <= CS_IDLE;
      rsp_valid  <= 2'b00;
      rx_data    <= 8'd0;
    end else begin
      rsp_valid <= 2'b00;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= winner;
            last_grant <= winner;
            hold_flag  <= hold_cs[winner];
            spi_cs     <= ~req_onehot(winner);
            state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (shift_done) begin
            rsp_valid <= req_onehot(owner);
            rx_data   <= shift_rx;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (hold_flag) begin
            state <= ST_HOLD;
          end else begin
            spi_cs  <= CS_IDLE;
            gap_cnt <= GAP_LOAD;
            state   <= AFTER_RELEASE;
          end
        end
        ST_HOLD: begin
          // A new byte from the owner takes precedence over a same-cycle release.
          if (accept) begin
            hold_flag <= hold_cs[owner];
            state     <= ST_XFER;
          end else if (release_cs[owner]) begin
            spi_cs  <= CS_IDLE;
            gap_cnt <= GAP_LOAD;
            state   <= AFTER_RELEASE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) state <= ST_IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: drivers issue bytes, a negedge monitor
// tracks an abstract bus model (busy/locked/gap/idle), pushes the expected
// response at each accept and pops/compares it on every rsp_valid pulse.
module tb_spi_bus_arbiter;

  localparam int DIVIDE     = 4;
  localparam int GAP        = 2;
  localparam int LAT_IDLE   = 17 * DIVIDE + 1;
  localparam int LAT_HOLD   = 16 * DIVIDE + 1;
  localparam int ACC_BUDGET = 2000;
  localparam int RSP_BUDGET = 500;

  logic       clk;
  logic       reset_n;
  logic [1:0] req_valid, req_ready, hold_cs, release_cs, rsp_valid, spi_cs;
  logic [7:0] tx_data_0, tx_data_1, rx_data;
  logic       busy, spi_clk, spi_mosi, spi_miso;

  logic       drv_valid [2];
  logic [7:0] drv_tx    [2];
  logic       drv_hold  [2];
  logic       drv_rel   [2];
  logic       loopback;
  logic       slave_bit;

  assign req_valid  = {drv_valid[1], drv_valid[0]};
  assign hold_cs    = {drv_hold[1], drv_hold[0]};
  assign release_cs = {drv_rel[1], drv_rel[0]};
  assign tx_data_0  = drv_tx[0];
  assign tx_data_1  = drv_tx[1];
  assign spi_miso   = loopback ? spi_mosi : slave_bit;

  spi_bus_arbiter #(.DIVIDE(DIVIDE), .GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .tx_data_0  (tx_data_0),
    .tx_data_1  (tx_data_1),
    .hold_cs    (hold_cs),
    .release_cs (release_cs),
    .rsp_valid  (rsp_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs     (spi_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot2(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Expected IDLE grant: a single request wins, a tie goes to the requester not served last.
  function automatic logic [1:0] exp_idle_ready(input logic [1:0] v, input int last);
    case (v)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return (last == 0) ? 2'b10 : 2'b01;
    endcase
  endfunction

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] rx;
    bit         hold;
    bit         from_hold;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  // Abstract bus model
  bit         m_busy = 0, m_locked = 0;
  int         m_owner = 0, m_last = 1, m_idle_from = 0;
  logic [7:0] m_rx_last = 8'd0;
  logic [7:0] slave_pat = 8'd0;
  int         slave_idx = 7;
  logic       prev_sclk = 1'b0;
  int         rise_cnt = 0;
  logic [7:0] mosi_cap = 8'd0;
  bit         force_pat_en = 0;
  logic [7:0] force_pat = 8'd0;

  exp_t       mon_e;
  logic [1:0] e_ready, e_cs, acc;
  logic       e_busy;

  // Monitor: invariants, SPI line observation, scoreboard pop and push.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_busy = 0; m_locked = 0; m_owner = 0; m_last = 1; m_idle_from = 0;
      m_rx_last = 8'd0; prev_sclk = 1'b0; rise_cnt = 0; mosi_cap = 8'd0;
      exp_q.delete();
    end else begin
      if (m_busy) begin
        e_ready = 2'b00; e_busy = 1'b1; e_cs = ~onehot2(m_owner);
      end else if (m_locked) begin
        e_ready = onehot2(m_owner); e_busy = 1'b1; e_cs = ~onehot2(m_owner);
      end else if (cyc < m_idle_from) begin
        e_ready = 2'b00; e_busy = 1'b1; e_cs = 2'b11;
      end else begin
        e_ready = exp_idle_ready(req_valid, m_last); e_busy = 1'b0; e_cs = 2'b11;
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("spi_cs", 32'(spi_cs), 32'(e_cs));
      if (!m_busy) check("sclk_idle_low", 32'(spi_clk), 0);
      if (rsp_valid == 2'b00) check("rx_data_held", 32'(rx_data), 32'(m_rx_last));

      if (spi_clk && !prev_sclk) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
      end
      if (!spi_clk && prev_sclk) begin
        slave_idx = (slave_idx == 0) ? 7 : slave_idx - 1;
        slave_bit = slave_pat[slave_idx];
      end
      prev_sclk = spi_clk;

      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_owner", 32'(rsp_valid), 32'(onehot2(mon_e.idx)));
          check("rx_data", 32'(rx_data), 32'(mon_e.rx));
          check("mosi_byte", 32'(mosi_cap), 32'(mon_e.tx));
          check("sclk_rises", 32'(rise_cnt), 8);
          check("latency", 32'(cyc - mon_e.acc_cyc),
                32'(mon_e.from_hold ? LAT_HOLD : LAT_IDLE));
          m_busy    = 0;
          m_rx_last = mon_e.rx;
          if (mon_e.hold) m_locked = 1;
          else            m_idle_from = cyc + 1 + GAP;
        end
      end

      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        mon_e.idx       = acc[1] ? 1 : 0;
        mon_e.from_hold = m_locked;
        mon_e.tx        = acc[1] ? tx_data_1 : tx_data_0;
        mon_e.hold      = hold_cs[mon_e.idx];
        mon_e.acc_cyc   = cyc;
        slave_pat       = force_pat_en ? force_pat : 8'($urandom);
        slave_idx       = 7;
        slave_bit       = slave_pat[7];
        mon_e.rx        = loopback ? mon_e.tx : slave_pat;
        m_locked = 0; m_busy = 1; m_owner = mon_e.idx; m_last = mon_e.idx;
        rise_cnt = 0; mosi_cap = 8'd0;
        exp_q.push_back(mon_e);
        grant_log.push_back(mon_e.idx);
      end else if (m_locked && release_cs[m_owner]) begin
        m_locked    = 0;
        m_idle_from = cyc + 1 + GAP;
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] d, input bit h, input bit rel);
    int n;
    @(posedge clk); #1;
    drv_valid[i] = 1'b1; drv_tx[i] = d; drv_hold[i] = h; drv_rel[i] = rel;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < ACC_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_in_budget_req%0d", i), 32'(n < ACC_BUDGET), 1);
    @(posedge clk); #1;
    drv_valid[i] = 1'b0; drv_rel[i] = 1'b0;
    drv_tx[i] = 8'($urandom); drv_hold[i] = 1'($urandom);
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid[i] && n < RSP_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("rsp_in_budget_req%0d", i), 32'(n < RSP_BUDGET), 1);
  endtask

  task automatic release_pulse(input int i);
    @(posedge clk); #1 drv_rel[i] = 1'b1;
    @(posedge clk); #1 drv_rel[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || m_locked) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_budget", 32'(n < 3000), 1);
  endtask

  task automatic rand_requester(input int i, input int bursts);
    int len;
    bit h, rel;
    for (int b = 0; b < bursts; b++) begin
      len = $urandom_range(1, 3);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      for (int k = 0; k < len; k++) begin
        h   = (k < len - 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
        rel = (k > 0) && ($urandom_range(0, 3) == 0);
        send_byte(i, 8'($urandom), h, rel);
        wait_rsp(i);
        if (k == len - 1 && h) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          release_pulse(i);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int rises;
    logic ps;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0; drv_tx[i] = 8'd0; drv_hold[i] = 1'b0; drv_rel[i] = 1'b0;
    end
    loopback  = 1'b1;
    slave_bit = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(spi_cs), 32'h3);
    check("rst_sclk", 32'(spi_clk), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_rx", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // Tie with both requesters continuously pending: grants alternate from requester 0.
    grant_log.delete();
    fork
      begin send_byte(0, 8'h11, 0, 0); send_byte(0, 8'h22, 0, 0); end
      begin send_byte(1, 8'h33, 0, 0); send_byte(1, 8'h44, 0, 0); end
    join
    wait_idle();
    check("tie_grant_count", 32'(grant_log.size()), 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      check($sformatf("tie_grant_%0d", k), 32'(grant_log[k]), 32'(k % 2));

    // Single loopback transfer of 0xA5.
    send_byte(0, 8'hA5, 0, 0);
    wait_rsp(0);
    check("single_rx", 32'(rx_data), 32'hA5);
    wait_idle();

    // Lock: requester 0 holds CS across two bytes while requester 1 waits.
    fork
      begin
        send_byte(0, 8'h40, 1, 0);
        wait_rsp(0);
        send_byte(0, 8'h81, 1, 0);
        wait_rsp(0);
        release_pulse(1);
        release_pulse(0);
      end
      begin
        repeat (3) @(posedge clk);
        send_byte(1, 8'hC3, 0, 0);
        wait_rsp(1);
      end
    join
    wait_idle();

    // Request and release together in HOLD: the byte wins.
    send_byte(0, 8'h5E, 1, 0);
    wait_rsp(0);
    send_byte(0, 8'h7A, 0, 1);
    wait_rsp(0);
    wait_idle();

    // MISO capture with a fixed slave pattern.
    loopback = 1'b0; force_pat_en = 1; force_pat = 8'h3C;
    send_byte(0, 8'hFF, 0, 0);
    wait_rsp(0);
    check("miso_capture", 32'(rx_data), 32'h3C);
    wait_idle();
    force_pat_en = 0; loopback = 1'b1;

    // Reset after the third SCLK rising edge of a byte.
    send_byte(1, 8'h96, 0, 0);
    rises = 0; ps = spi_clk;
    for (int n = 0; n < 200 && rises < 3; n++) begin
      @(negedge clk);
      if (spi_clk && !ps) rises++;
      ps = spi_clk;
    end
    check("three_sclk_rises", 32'(rises), 3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(spi_cs), 32'h3);
    check("midrst_sclk", 32'(spi_clk), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rsp", 32'(rsp_valid), 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    reset_n = 1'b1;
    send_byte(1, 8'h5B, 0, 0);
    wait_rsp(1);
    check("post_rst_rx", 32'(rx_data), 32'h5B);
    wait_idle();

    // Randomized traffic from both requesters against a random slave.
    loopback = 1'b0;
    fork
      rand_requester(0, 12);
      rand_requester(1, 12);
    join
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
